// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, drives the ROM address and hands
// captured instruction words to the decoder over valid/ready.
module instr_fetch_unit #(
  parameter int ADDR_W = 14,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_data,
  output logic              instr_valid,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              fetch_halted,
  output logic [31:0]       fetch_count
);

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  state_t            state;
  state_t            state_n;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] redir_al;
  logic              zero_word;
  logic              capture;
  logic              handshake;

  assign redir_al    = redirect_pc & ~ADDR_W'(3);
  assign zero_word   = (rom_data == 32'h0);
  assign rom_addr    = pc;
  assign instr_valid = (state == S_VALID);
  assign fetch_halted = (state == S_HALT);

  assign capture   = (state == S_WAIT) && !zero_word
                     && !redirect_valid;
  assign handshake = (state == S_VALID) && instr_ready
                     && !redirect_valid;

  // Next-state logic; a redirect overrides every transition.
  always_comb begin
    state_n = state;
    unique case (state)
      S_REQ:   state_n = S_WAIT;
      S_WAIT:  state_n = zero_word ? S_HALT : S_VALID;
      S_VALID: state_n = instr_ready ? S_WAIT : S_VALID;
      S_HALT:  state_n = S_HALT;
    endcase
    if (redirect_valid)
      state_n = S_REQ;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= S_REQ;
    else
      state <= state_n;
  end

  // PC: reload on redirect, advance when a word is captured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      pc <= RESET_PC;
    else if (redirect_valid)
      pc <= redir_al;
    else if (capture)
      pc <= pc + ADDR_W'(4);
  end

  // Instruction register and its address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (capture) begin
      instr    <= rom_data;
      instr_pc <= pc;
    end
  end

  // Completed handshake counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= '0;
    else if (handshake)
      fetch_count <= fetch_count + 32'd1;
  end

endmodule
